// File: rtl/mux_arb_pkg.sv
// Shared constants for the arbitrating multiplexer: selection modes and a
// small index helper used for the round-robin pointer update.
package mux_arb_pkg;

    localparam int MODE_RR   = 0;  // round-robin starting at the pointer
    localparam int MODE_PRIO = 1;  // fixed priority, channel 0 highest
    localparam int MODE_SEL  = 2;  // external select input

    // Next channel index after idx, wrapping from n-1 back to 0.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational grant selection for N requesters. The round-robin search
// masks off requesters below the pointer and falls back to the unmasked
// vector when nothing at or above the pointer is requesting, which keeps
// the request-to-grant path a pair of priority encoders.
module rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int N    = 4,
    parameter int MODE = MODE_RR,
    parameter int SW   = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    input  logic [SW-1:0] sel,
    input  logic          en,
    output logic [N-1:0]  grant,
    output logic [SW-1:0] grant_idx,
    output logic          grant_any
);

    logic [N-1:0] hi_req;
    logic         found;
    int           idx_int;

    // Requesters at or above the round-robin pointer.
    for (genvar gi = 0; gi < N; gi++) begin : g_mask
        assign hi_req[gi] = req[gi] && (gi >= int'(ptr));
    end

    // Pick the winning channel index according to the selection mode.
    always_comb begin
        found   = 1'b0;
        idx_int = 0;
        case (MODE)
            MODE_SEL: begin
                if ((int'(sel) < N) && req[sel]) begin
                    found   = 1'b1;
                    idx_int = int'(sel);
                end
            end
            MODE_PRIO: begin
                for (int c = N - 1; c >= 0; c--) begin
                    if (req[c]) begin
                        found   = 1'b1;
                        idx_int = c;
                    end
                end
            end
            default: begin
                if (|hi_req) begin
                    for (int c = N - 1; c >= 0; c--) begin
                        if (hi_req[c]) begin
                            found   = 1'b1;
                            idx_int = c;
                        end
                    end
                end else begin
                    for (int c = N - 1; c >= 0; c--) begin
                        if (req[c]) begin
                            found   = 1'b1;
                            idx_int = c;
                        end
                    end
                end
            end
        endcase
    end

    assign grant_idx = SW'(idx_int);
    assign grant_any = en && found;

    // One-hot grant, suppressed entirely when the consumer side cannot load.
    for (genvar gi = 0; gi < N; gi++) begin : g_grant
        assign grant[gi] = grant_any && (grant_idx == SW'(gi));
    end

endmodule

// File: rtl/mux_arb_reg.sv
// N-input arbitrating multiplexer with a single registered output stage and
// valid/ready handshakes on every channel. A new word may be captured
// whenever the output register is empty or being drained this cycle, giving
// one word per cycle of throughput with one cycle of latency.
module mux_arb_reg
    import mux_arb_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int MODE  = MODE_RR,
    parameter int SW    = $clog2(N)
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]       in_ready,
    input  logic [SW-1:0]      sel,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SW-1:0]      out_src,
    input  logic               out_ready
);

    logic             load;
    logic [SW-1:0]    ptr;
    logic [N-1:0]     grant;
    logic [SW-1:0]    grant_idx;
    logic             grant_any;
    logic [WIDTH-1:0] chan [N];

    // Unpack the flat data bus so the data mux is a plain index on grant_idx.
    for (genvar gi = 0; gi < N; gi++) begin : g_chan
        assign chan[gi] = in_data[gi*WIDTH +: WIDTH];
    end

    // Reset is folded in so no channel sees ready while the block is held.
    assign load = (!out_valid || out_ready) && clrn;

    rr_arbiter #(
        .N    (N),
        .MODE (MODE),
        .SW   (SW)
    ) u_arb (
        .req       (in_valid),
        .ptr       (ptr),
        .sel       (sel),
        .en        (load),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign in_ready = grant;

    // Output register: reload on a grant, empty on a drain with no grant,
    // hold under backpressure.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else if (load) begin
            if (grant_any) begin
                out_valid <= 1'b1;
                out_data  <= chan[grant_idx];
                out_src   <= grant_idx;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    // Round-robin pointer moves just past the channel that won.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            ptr <= '0;
        end else if ((MODE == MODE_RR) && grant_any) begin
            ptr <= SW'(wrap_inc(int'(grant_idx), N));
        end
    end

endmodule

// File: tb/tb_mux_arb_reg.sv
// Bench for mux_arb_reg: four instances (round-robin N=4, round-robin N=3,
// fixed priority N=4, external select N=3) share stimulus and are compared
// every cycle against a per-instance transaction-level reference model.
module tb_mux_arb_reg;

    logic         clk;
    logic         clrn;
    logic [3:0]   v;
    logic [1:0]   sel;
    logic [3:0]   ordy;
    logic [31:0]  dat [4];
    logic [127:0] din4;

    logic [3:0]   r0, r2;
    logic [2:0]   r1, r3;
    logic         ov0, ov1, ov2, ov3;
    logic [31:0]  od0, od1, od2, od3;
    logic [1:0]   os0, os1, os2, os3;

    logic [3:0]   rdy_a [4];
    logic         ov_a  [4];
    logic [31:0]  od_a  [4];
    logic [1:0]   os_a  [4];

    int checks = 0;
    int errors = 0;

    // Reference model state per instance.
    int          nn [4] = '{4, 3, 4, 3};
    int          md [4] = '{0, 0, 1, 2};
    int          m_ptr [4];
    bit          m_ov  [4];
    logic [31:0] m_od  [4];
    int          m_os  [4];

    assign din4 = {dat[3], dat[2], dat[1], dat[0]};

    mux_arb_reg #(.WIDTH(32), .N(4), .MODE(0)) u_rr4 (
        .clk(clk), .clrn(clrn), .in_valid(v), .in_data(din4), .in_ready(r0),
        .sel(sel), .out_valid(ov0), .out_data(od0), .out_src(os0), .out_ready(ordy[0]));
    mux_arb_reg #(.WIDTH(32), .N(3), .MODE(0)) u_rr3 (
        .clk(clk), .clrn(clrn), .in_valid(v[2:0]), .in_data(din4[95:0]), .in_ready(r1),
        .sel(sel), .out_valid(ov1), .out_data(od1), .out_src(os1), .out_ready(ordy[1]));
    mux_arb_reg #(.WIDTH(32), .N(4), .MODE(1)) u_pr4 (
        .clk(clk), .clrn(clrn), .in_valid(v), .in_data(din4), .in_ready(r2),
        .sel(sel), .out_valid(ov2), .out_data(od2), .out_src(os2), .out_ready(ordy[2]));
    mux_arb_reg #(.WIDTH(32), .N(3), .MODE(2)) u_sel3 (
        .clk(clk), .clrn(clrn), .in_valid(v[2:0]), .in_data(din4[95:0]), .in_ready(r3),
        .sel(sel), .out_valid(ov3), .out_data(od3), .out_src(os3), .out_ready(ordy[3]));

    assign rdy_a[0] = r0;
    assign rdy_a[1] = {1'b0, r1};
    assign rdy_a[2] = r2;
    assign rdy_a[3] = {1'b0, r3};
    assign ov_a[0] = ov0;
    assign ov_a[1] = ov1;
    assign ov_a[2] = ov2;
    assign ov_a[3] = ov3;
    assign od_a[0] = od0;
    assign od_a[1] = od1;
    assign od_a[2] = od2;
    assign od_a[3] = od3;
    assign os_a[0] = os0;
    assign os_a[1] = os1;
    assign os_a[2] = os2;
    assign os_a[3] = os3;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Channel the model expects to win this cycle, or -1 for none.
    function automatic int mgrant(input int d);
        int n;
        int g;
        int c;
        n = nn[d];
        g = -1;
        if (!m_ov[d] || ordy[d]) begin
            if (md[d] == 0) begin
                for (int k = 0; k < n; k++) begin
                    c = (m_ptr[d] + k) % n;
                    if (g < 0 && v[c]) g = c;
                end
            end else if (md[d] == 1) begin
                for (int k = 0; k < n; k++) begin
                    if (g < 0 && v[k]) g = k;
                end
            end else begin
                if (int'(sel) < n && v[sel]) g = int'(sel);
            end
        end
        return g;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 4; d++) begin
            m_ptr[d] = 0;
            m_ov[d]  = 1'b0;
            m_od[d]  = '0;
            m_os[d]  = 0;
        end
    endtask

    // One clock cycle: called with clk low and inputs already driven.
    task automatic step();
        int g [4];
        for (int d = 0; d < 4; d++) g[d] = mgrant(d);
        #1;
        for (int d = 0; d < 4; d++)
            chk($sformatf("in_ready%0d", d), 32'(rdy_a[d]), (g[d] >= 0) ? 32'(1 << g[d]) : 32'd0);
        @(posedge clk);
        for (int d = 0; d < 4; d++) begin
            if (!m_ov[d] || ordy[d]) begin
                if (g[d] >= 0) begin
                    m_ov[d] = 1'b1;
                    m_od[d] = dat[g[d]];
                    m_os[d] = g[d];
                    if (md[d] == 0) m_ptr[d] = (g[d] + 1) % nn[d];
                end else begin
                    m_ov[d] = 1'b0;
                end
            end
        end
        #1;
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("out_valid%0d", d), 32'(ov_a[d]), 32'(m_ov[d]));
            chk($sformatf("out_data%0d", d), od_a[d], m_od[d]);
            chk($sformatf("out_src%0d", d), 32'(os_a[d]), 32'(m_os[d]));
        end
        $display("step t=%0t v=%b sel=%0d ordy=%b src=%0d/%0d/%0d/%0d", $time, v, sel, ordy,
                 os_a[0], os_a[1], os_a[2], os_a[3]);
        @(negedge clk);
    endtask

    // Asynchronous reset asserted in the low phase, released at a negedge.
    task automatic do_reset();
        #2 clrn = 1'b0;
        #1;
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("rst_valid%0d", d), 32'(ov_a[d]), 32'd0);
            chk($sformatf("rst_data%0d", d), od_a[d], 32'd0);
            chk($sformatf("rst_src%0d", d), 32'(os_a[d]), 32'd0);
            chk($sformatf("rst_ready%0d", d), 32'(rdy_a[d]), 32'd0);
        end
        model_reset();
        @(negedge clk);
        clrn = 1'b1;
        $display("reset t=%0t", $time);
    endtask

    initial begin
        clrn = 1'b0;
        v    = '0;
        sel  = '0;
        ordy = '0;
        for (int i = 0; i < 4; i++) dat[i] = '0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Round-robin with every channel valid: 0,1,2,3,0 and 0,1,2,0,1.
        v = 4'hF;
        ordy = 4'hF;
        for (int i = 0; i < 4; i++) dat[i] = 32'(i);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("rr4_seq", 32'(os_a[0]), 32'(k % 4));
            chk("rr4_data", od_a[0], 32'(k % 4));
            chk("rr4_full", 32'(ov_a[0]), 32'd1);
            chk("rr3_seq", 32'(os_a[1]), 32'(k % 3));
        end

        // N=3, pointer now at 2, only channels 2 and 0 valid.
        v = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("rr3_wrap", 32'(os_a[1]), (k % 2 == 0) ? 32'd2 : 32'd0);
        end

        // Backpressure holding 0xDEADBEEF on the N=4 round-robin instance.
        dat[2] = 32'hDEADBEEF;
        v = 4'b0100;
        step();
        chk("bp_load", od_a[0], 32'hDEADBEEF);
        ordy[0] = 1'b0;
        v = 4'hF;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_hold", od_a[0], 32'hDEADBEEF);
            chk("bp_ready", 32'(rdy_a[0]), 32'd0);
        end
        ordy[0] = 1'b1;
        step();
        chk("bp_reload_valid", 32'(ov_a[0]), 32'd1);
        chk("bp_reload_src", 32'(os_a[0]), 32'd3);

        // Fixed priority: channel 1 wins, channel 3 starves until 1 drops.
        v = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("prio_src", 32'(os_a[2]), 32'd1);
        end
        v = 4'b1000;
        step();
        chk("prio_starve_end", 32'(os_a[2]), 32'd3);

        // External select of an idle channel drains the output.
        sel = 2'd2;
        v = 4'b0011;
        step();
        step();
        chk("sel_drain", 32'(ov_a[3]), 32'd0);
        v = 4'b0100;
        dat[2] = 32'h12345678;
        step();
        chk("sel_data", od_a[3], 32'h12345678);
        chk("sel_src", 32'(os_a[3]), 32'd2);
        sel = 2'd3;
        v = 4'b0111;
        step();
        chk("sel_out_of_range", 32'(ov_a[3]), 32'd0);

        // Reset in the middle of a stream, then first grant is channel 0.
        v = 4'hF;
        ordy = 4'hF;
        sel = 2'd1;
        step();
        do_reset();
        step();
        chk("post_rst_src", 32'(os_a[0]), 32'd0);

        // Randomized traffic with occasional resets.
        for (int it = 0; it < 400; it++) begin
            v = 4'($urandom);
            sel = 2'($urandom_range(0, 3));
            for (int d = 0; d < 4; d++) ordy[d] = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++) dat[i] = $urandom;
            if ($urandom_range(0, 99) == 0) do_reset();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_arb_reg.md
# mux_arb_reg

Parametrised N-input, W-bit arbitrating multiplexer with a registered output stage and valid/ready handshakes on every channel. It is the sequential successor to the fixed 4×32 combinational selector in the datapath. It merges several producers, such as a PC source, writeback source or memory-request port, onto one consumer. Three selection modes are supported: round-robin, fixed priority and external select.

## Interface
- WIDTH, 32: data width per channel.
- N, 4: number of input channels, N ≥ 2; need not be a power of two.
- MODE, 0: 0 = round-robin, 1 = fixed priority (channel 0 highest), 2 = external select via `sel`.
- SW, $clog2(N): width of `sel` and `out_src`.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- clrn  in  1  reset, asynchronous, active-low.
- in_valid  in  N  per-channel request.
- in_data  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  out  N  one-hot-or-zero; channel i transfers when in_valid[i] && in_ready[i].
- sel  in  SW  channel index, used only when MODE=2.
- out_valid  out  1  output register holds data.
- out_data  out  WIDTH  registered data.
- out_src  out  SW  index of the channel that supplied out_data.
- out_ready  in  1  consumer accepts when out_valid && out_ready.

## Operation
- `load = !out_valid || out_ready`. The output register may accept a word this cycle only when `load` is high.
- Grant selection is combinational from in_valid and state:
  - MODE 0: the first valid channel scanning from `ptr` upward, wrapping from N-1 to 0.
  - MODE 1: the lowest-index valid channel.
  - MODE 2: channel `sel` if in_valid[sel], else none. A `sel` ≥ N grants none.
- in_ready[i] = load && grant[i]. At most one bit is set. in_ready depends combinationally on in_valid, sel and out_ready; there is no dependence from in_ready back to in_valid.
- On a transfer: out_data ← in_data[g], out_src ← g, out_valid ← 1.
  - MODE 0 also sets ptr ← (g == N-1) ? 0 : g+1.
- Output handshake with no new grant: out_valid ← 0. out_data and out_src hold their last values.
- No valid input, or load low: no grant, and ptr is unchanged.
- Simultaneous output handshake and new grant in the same cycle: the register reloads and out_valid stays 1. Full throughput is one word per cycle.
- Backpressure: while out_valid && !out_ready, all in_ready are 0 and out_data, out_src and out_valid stay stable.
- Reset, including mid-transfer: out_valid=0, out_data=0, out_src=0, ptr=0. Any word in flight is dropped.

## Timing
- Latency is 1 cycle: a word accepted at edge k appears on out_data after edge k and is consumable in cycle k+1.
- Throughput is 1 word per cycle with out_ready held high.
- Reset values: out_valid 0, out_data 0, out_src 0, in_ready 0 while clrn is low. ptr is internal and resets to 0.
- The combinational path in_valid/out_ready → in_ready is the critical path and must stay within one cycle for N ≤ 16.
- Fairness: in MODE 0 with all channels continuously valid and out_ready high, each channel is granted exactly once every N cycles.

## Structure
- Shared package `mux_arb_pkg`: mode constants `MODE_RR=0`, `MODE_PRIO=1`, `MODE_SEL=2`.
- One sub-module, `rr_arbiter`. It has N parameters, takes `req[N]`, `ptr`, `en` and `MODE`, and outputs one-hot `grant` plus `grant_idx`.
- The top level holds the output register, the ptr update and the data mux. The mux is an indexed part-select on grant_idx.
- Every register has asynchronous reset on negedge clrn.

## Test plan
- Reset: assert clrn=0 mid-stream with out_valid=1 → out_valid=0, out_data=0 and in_ready=0 immediately. After release, the first grant with all valid is channel 0 (MODE 0).
- Round-robin, N=4: all valid, out_ready=1, data = channel index → out_src sequence 0,1,2,3,0,… One word per cycle, first output 1 cycle after release.
- Non-power-of-two, N=3, MODE 0: only channels 2 and 0 valid, starting with ptr=2 → grants 2,0,2,0. ptr wraps from 2 to 0 and never reaches 3.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 and data 0xDEADBEEF → out_data stable, all in_ready=0. On release, 0xDEADBEEF handshakes and the next grant loads in the same cycle.
- MODE 1: valid = 4'b1010 → out_src=1 repeatedly. Channel 3 starves until in_valid[1] drops.
- MODE 2: sel=2 with in_valid[2]=0 and other channels valid → no grant and out_valid falls after a drain. Setting in_valid[2]=1, in_data=0x12345678 → out_data=0x12345678, out_src=2 next cycle.
